// File: rtl/ecc_point_add_if.sv
// Operand/result bundle for the secp256k1 affine point adder.
// The master side issues the operands and the slave side returns the result.
interface ecc_point_add_if;
   logic         in_valid;
   logic [255:0] Px;
   logic [255:0] Py;
   logic [255:0] Qx;
   logic [255:0] Qy;
   logic         out_valid;
   logic [255:0] Rx;
   logic [255:0] Ry;
   logic         out_inf;
   logic         err;
   logic         busy;

   modport master (
      output in_valid, Px, Py, Qx, Qy,
      input  out_valid, Rx, Ry, out_inf, err, busy
   );

   modport slave (
      input  in_valid, Px, Py, Qx, Qy,
      output out_valid, Rx, Ry, out_inf, err, busy
   );
endinterface

// File: rtl/ecc_point_add.sv
// Affine point addition R = P + Q on secp256k1 (a=0, b=7).
// Field arithmetic is fully reduced after every operation.
// The multiplier is bit-serial (MSB first), one bit per cycle.
// The inverter is binary extended Euclid, one halving step per cycle.
// Optional feature macro: ECC_DOUBLE_EN enables point doubling (P == Q).
// Without ECC_DOUBLE_EN, P == Q is reported through err.
module ecc_point_add (
   input  logic           clk,
   input  logic           rst,
   ecc_point_add_if.slave bus
);

   localparam logic [255:0] P_MOD =
      256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

   typedef enum logic [3:0] {
      IDLE,
      DIFF,
`ifdef ECC_DOUBLE_EN
      DBL_SQ,
`endif
      INV,
      MUL_L,
      MUL_SQ,
      SUB_X,
      MUL_Y,
      SUB_Y,
      DONE
   } state_t;

   // a + b mod p for a, b already in [0, p)
   function automatic logic [255:0] mod_add(input logic [255:0] a, input logic [255:0] b);
      logic [256:0] s;
      logic [256:0] r;
      s = {1'b0, a} + {1'b0, b};
      r = (s >= {1'b0, P_MOD}) ? (s - {1'b0, P_MOD}) : s;
      return r[255:0];
   endfunction

   // a - b mod p for a, b already in [0, p)
   function automatic logic [255:0] mod_sub(input logic [255:0] a, input logic [255:0] b);
      logic [256:0] d;
      d = {1'b0, a} - {1'b0, b};
      return d[256] ? (d[255:0] + P_MOD) : d[255:0];
   endfunction

   // x / 2 mod p: add p first when x is odd so the shift is exact
   function automatic logic [255:0] mod_half(input logic [255:0] x);
      logic [256:0] s;
      s = x[0] ? ({1'b0, x} + {1'b0, P_MOD}) : {1'b0, x};
      return s[256:1];
   endfunction

   // One interleaved multiply step: acc = 2*acc + bit*a mod p
   function automatic logic [255:0] mul_step(input logic [255:0] acc, input logic [255:0] a,
                                             input logic bit_in);
      logic [255:0] d;
      d = mod_add(acc, acc);
      return bit_in ? mod_add(d, a) : d;
   endfunction

   state_t       state;

   logic [255:0] px_r;
   logic [255:0] py_r;
   logic [255:0] qx_r;
   logic [255:0] qy_r;
   logic [255:0] num_r;
   logic [255:0] lam_r;
   logic [255:0] tmp_r;
   logic [255:0] rx_r;

   logic [255:0] mul_a;
   logic [255:0] mul_b;
   logic [255:0] mul_acc;
   logic [7:0]   mul_cnt;

   logic [255:0] inv_u;
   logic [255:0] inv_v;
   logic [255:0] inv_x1;
   logic [255:0] inv_x2;

   logic         out_valid_r;
   logic [255:0] rx_o;
   logic [255:0] ry_o;
   logic         inf_o;
   logic         err_o;
   logic         busy_r;

   logic [255:0] mul_next;
   logic         mul_last;
   logic [255:0] inv_u_n;
   logic [255:0] inv_v_n;
   logic [255:0] inv_x1_n;
   logic [255:0] inv_x2_n;
   logic         inv_done;
   logic [255:0] inv_res;
   logic [255:0] rx_new;
   logic [255:0] px_minus_rx;
   logic [255:0] ry_new;

   assign bus.out_valid = out_valid_r;
   assign bus.Rx        = rx_o;
   assign bus.Ry        = ry_o;
   assign bus.out_inf   = inf_o;
   assign bus.err       = err_o;
   assign bus.busy      = busy_r;

   // Next multiplier accumulator; the last step consumes the original LSB of the multiplier
   always_comb begin
      mul_next = mul_step(mul_acc, mul_a, mul_b[255]);
      mul_last = (mul_cnt == 8'd255);
   end

   // One Euclid iteration; the odd/odd case subtracts and halves together so
   // the combined bit length of u and v drops every cycle
   always_comb begin
      inv_u_n  = inv_u;
      inv_v_n  = inv_v;
      inv_x1_n = inv_x1;
      inv_x2_n = inv_x2;
      if (!inv_u[0]) begin
         inv_u_n  = inv_u >> 1;
         inv_x1_n = mod_half(inv_x1);
      end else if (!inv_v[0]) begin
         inv_v_n  = inv_v >> 1;
         inv_x2_n = mod_half(inv_x2);
      end else if (inv_u >= inv_v) begin
         inv_u_n  = (inv_u - inv_v) >> 1;
         inv_x1_n = mod_half(mod_sub(inv_x1, inv_x2));
      end else begin
         inv_v_n  = (inv_v - inv_u) >> 1;
         inv_x2_n = mod_half(mod_sub(inv_x2, inv_x1));
      end
      inv_done = (inv_u == 256'd1) || (inv_v == 256'd1);
      inv_res  = (inv_u == 256'd1) ? inv_x1 : inv_x2;
   end

   // Final subtractions for the result coordinates, taken from tmp_r
   always_comb begin
      rx_new      = mod_sub(mod_sub(tmp_r, px_r), qx_r);
      px_minus_rx = mod_sub(px_r, rx_new);
      ry_new      = mod_sub(tmp_r, py_r);
   end

   // Control FSM plus all datapath and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         px_r        <= '0;
         py_r        <= '0;
         qx_r        <= '0;
         qy_r        <= '0;
         num_r       <= '0;
         lam_r       <= '0;
         tmp_r       <= '0;
         rx_r        <= '0;
         mul_a       <= '0;
         mul_b       <= '0;
         mul_acc     <= '0;
         mul_cnt     <= '0;
         inv_u       <= '0;
         inv_v       <= '0;
         inv_x1      <= '0;
         inv_x2      <= '0;
         out_valid_r <= 1'b0;
         rx_o        <= '0;
         ry_o        <= '0;
         inf_o       <= 1'b0;
         err_o       <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  px_r   <= bus.Px;
                  py_r   <= bus.Py;
                  qx_r   <= bus.Qx;
                  qy_r   <= bus.Qy;
                  busy_r <= 1'b1;
                  state  <= DIFF;
               end
            end

            DIFF: begin
               if (px_r != qx_r) begin
                  num_r  <= mod_sub(qy_r, py_r);
                  inv_u  <= mod_sub(qx_r, px_r);
                  inv_v  <= P_MOD;
                  inv_x1 <= 256'd1;
                  inv_x2 <= '0;
                  state  <= INV;
               end else if (py_r != qy_r) begin
                  rx_o        <= '0;
                  ry_o        <= '0;
                  inf_o       <= 1'b1;
                  err_o       <= 1'b0;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
               end else begin
`ifdef ECC_DOUBLE_EN
                  if (py_r == '0) begin
                     rx_o        <= '0;
                     ry_o        <= '0;
                     inf_o       <= 1'b1;
                     err_o       <= 1'b0;
                     out_valid_r <= 1'b1;
                     state       <= DONE;
                  end else begin
                     mul_a   <= px_r;
                     mul_b   <= px_r;
                     mul_acc <= '0;
                     mul_cnt <= '0;
                     state   <= DBL_SQ;
                  end
`else
                  rx_o        <= '0;
                  ry_o        <= '0;
                  inf_o       <= 1'b0;
                  err_o       <= 1'b1;
                  out_valid_r <= 1'b1;
                  state       <= DONE;
`endif
               end
            end

`ifdef ECC_DOUBLE_EN
            DBL_SQ: begin
               if (mul_last) begin
                  num_r  <= mod_add(mod_add(mul_next, mul_next), mul_next);
                  inv_u  <= mod_add(py_r, py_r);
                  inv_v  <= P_MOD;
                  inv_x1 <= 256'd1;
                  inv_x2 <= '0;
                  state  <= INV;
               end else begin
                  mul_acc <= mul_next;
                  mul_b   <= {mul_b[254:0], 1'b0};
                  mul_cnt <= mul_cnt + 8'd1;
               end
            end
`endif

            INV: begin
               if (inv_done) begin
                  mul_a   <= num_r;
                  mul_b   <= inv_res;
                  mul_acc <= '0;
                  mul_cnt <= '0;
                  state   <= MUL_L;
               end else begin
                  inv_u  <= inv_u_n;
                  inv_v  <= inv_v_n;
                  inv_x1 <= inv_x1_n;
                  inv_x2 <= inv_x2_n;
               end
            end

            MUL_L: begin
               if (mul_last) begin
                  lam_r   <= mul_next;
                  mul_a   <= mul_next;
                  mul_b   <= mul_next;
                  mul_acc <= '0;
                  mul_cnt <= '0;
                  state   <= MUL_SQ;
               end else begin
                  mul_acc <= mul_next;
                  mul_b   <= {mul_b[254:0], 1'b0};
                  mul_cnt <= mul_cnt + 8'd1;
               end
            end

            MUL_SQ: begin
               if (mul_last) begin
                  tmp_r <= mul_next;
                  state <= SUB_X;
               end else begin
                  mul_acc <= mul_next;
                  mul_b   <= {mul_b[254:0], 1'b0};
                  mul_cnt <= mul_cnt + 8'd1;
               end
            end

            SUB_X: begin
               rx_r    <= rx_new;
               mul_a   <= lam_r;
               mul_b   <= px_minus_rx;
               mul_acc <= '0;
               mul_cnt <= '0;
               state   <= MUL_Y;
            end

            MUL_Y: begin
               if (mul_last) begin
                  tmp_r <= mul_next;
                  state <= SUB_Y;
               end else begin
                  mul_acc <= mul_next;
                  mul_b   <= {mul_b[254:0], 1'b0};
                  mul_cnt <= mul_cnt + 8'd1;
               end
            end

            SUB_Y: begin
               rx_o        <= rx_r;
               ry_o        <= ry_new;
               inf_o       <= 1'b0;
               err_o       <= 1'b0;
               out_valid_r <= 1'b1;
               state       <= DONE;
            end

            DONE: begin
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               state       <= IDLE;
            end

            default: begin
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ecc_point_add.md
ECC_POINT_ADD -- requirements
Module: ecc_point_add

Interface
REQ-001 P_MOD, 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F, field prime (secp256k1, curve a=0, b=7).
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  one-cycle pulse qualifying Px/Py/Qx/Qy.
REQ-005 Px, Py, Qx, Qy  input  256 each  affine operands P and Q; values are < P_MOD.
REQ-006 out_valid  output  1  one-cycle pulse; Rx, Ry, out_inf and err are valid in that cycle.
REQ-007 Rx, Ry  output  256 each  affine result R = P + Q.
REQ-008 out_inf  output  1  result is the point at infinity.
REQ-009 err  output  1  operand pair not supported in the current build.
REQ-010 busy  output  1  high from the cycle after the accepted in_valid through the out_valid cycle.

Function
REQ-011 The block samples operands on the in_valid cycle only when in IDLE; in_valid while busy is ignored and does not alter the operation in progress.
REQ-012 The FSM states are IDLE, DIFF, INV, MUL_L, MUL_SQ, SUB_X, MUL_Y, SUB_Y, DONE; with ECC_DOUBLE_EN, DBL_SQ is added between DIFF and INV.
REQ-013 Field ops: add/sub reduce to [0, P_MOD) with one conditional correction; multiply is bit-serial interleaved, 1 bit/cycle, 256 iterations plus at most 2 correction cycles.
REQ-014 Inversion is binary extended Euclid, one iteration per cycle, at most 512 iterations; the result is fully reduced.
REQ-015 Add path (Px != Qx): lambda = (Qy-Py)*inv(Qx-Px); Rx = lambda^2 - Px - Qx; Ry = lambda*(Px-Rx) - Py; all mod P_MOD.
REQ-016 If Px == Qx and Py != Qy: out_inf=1, Rx=Ry=0, err=0; the block skips INV and MUL states and reaches DONE within 4 cycles of the accepted in_valid.
REQ-017 Latency: out_valid occurs no more than 2048 cycles after the accepted in_valid for every input.
REQ-018 The DONE state lasts exactly 1 cycle: out_valid=1 there, then the FSM returns to IDLE, and a new in_valid is accepted the next cycle.
REQ-019 Rx/Ry/out_inf/err hold their value from out_valid until the next out_valid.
REQ-020 in_valid arriving in the DONE cycle is ignored.

Reset
REQ-021 rst=1 at a clock edge forces IDLE, out_valid=0, busy=0, out_inf=0, err=0, Rx=Ry=0, and clears all datapath registers.
REQ-022 Reset mid-operation aborts with no out_valid; the next operation after reset returns a correct result.
REQ-023 in_valid during rst=1 is ignored.

Configuration
REQ-024 ECC_DOUBLE_EN defined: Px==Qx and Py==Qy with Py!=0 computes lambda = 3*Px^2 * inv(2*Py) and then follows REQ-015 for Rx/Ry; the case Py==Qy==0 gives out_inf=1; err is always 0.
REQ-025 ECC_DOUBLE_EN undefined: the case Px==Qx and Py==Qy gives err=1, out_inf=0, Rx=Ry=0 within 4 cycles; the DBL_SQ state and doubling datapath are absent.

Verification
Gx=79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798, Gy=483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8; 2G=(C6047F9441ED7D6D3045406E95C07CD85C778E4B8CEF3CA7ABAC09B95C709EE5, 1AE168FEA63DC339A3C58419466CEAEEF7F632653266D0E1236431A950CFE52A); 3G=(F9308A019258C31049344F85F89D5229B531C845836F99B08601F113BCE036F9, 388F7B0F632DE8140FE337E62A37F3566500A99934C2231B6CB9FD7584B8E672).
REQ-026 P=G, Q=2G -> out_valid within 2048 cycles with R=3G, out_inf=0, err=0; then swap P and Q -> the same R.
REQ-027 P=G, Q=(Gx, B7C52588D95C3B9AA25B0403F1EEF75702E84BB7597AABE663B82F6F04EF2777) -> out_inf=1, Rx=Ry=0 within 4 cycles.
REQ-028 P=Q=G -> with ECC_DOUBLE_EN, R=2G and err=0; without it, err=1 and Rx=Ry=0.
REQ-029 G+2G issued, then in_valid with other operands 10 cycles later -> single out_valid with R=3G; the second request is dropped and busy stays high throughout.
REQ-030 G+2G issued, rst pulsed 1 cycle at cycle 300 -> no out_valid, all outputs 0; then G+2G reissued -> R=3G.
REQ-031 256 back-to-back random additions against the golden file, next in_valid at the negedge after out_valid -> every result matches.
